// File: rtl/validador_pecas_if.sv
// Bus between the piece validator and its controller: check/commit/clear
// requests, status strobes, board read port and per-board cell counters.
interface validador_pecas_if;
  logic       valida;
  logic       grava;
  logic       limpa;
  logic       jogador;
  logic [2:0] tipo;
  logic [3:0] X1;
  logic [3:0] Y1;
  logic       direcao;
  logic       conflito;
  logic       pronto;
  logic       ocupado;
  logic       gravado;
  logic       rd_jogador;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic       rd_cel;
  logic [6:0] celulas0;
  logic [6:0] celulas1;

  modport master (
    output valida, grava, limpa, jogador, tipo, X1, Y1, direcao,
    output rd_jogador, rd_x, rd_y,
    input  conflito, pronto, ocupado, gravado, rd_cel, celulas0, celulas1
  );

  modport slave (
    input  valida, grava, limpa, jogador, tipo, X1, Y1, direcao,
    input  rd_jogador, rd_x, rd_y,
    output conflito, pronto, ocupado, gravado, rd_cel, celulas0, celulas1
  );
endinterface

// File: rtl/validador_pecas.sv
// Battleship piece validator: checks a piece against a 10x10 board one cell
// per cycle, commits validated pieces and clears boards, for two players.
module validador_pecas (
  input  logic              clk,
  input  logic              reset,
  validador_pecas_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CHECK, RESULT, COMMIT, CLEAR} state_t;

  state_t      state_q;
  logic [99:0] board_q    [2];
  logic [6:0]  celulas_q  [2];
  logic        jog_q;
  logic [2:0]  tipo_q;
  logic [3:0]  x_q;
  logic [3:0]  y_q;
  logic        dir_q;
  logic [2:0]  k_q;
  logic        apto_q;
  logic        conflito_q;
  logic        pronto_q;
  logic        gravado_q;
  logic        valida_prev_q;

  logic [2:0]  len_d;
  logic [4:0]  a_d, b_d, cx_d, cy_d;
  logic [6:0]  idx_d;
  logic        in_range_d, cell_conf_d, last_d, valida_edge_d;
  logic [6:0]  rd_idx_d;

  // Cell k of the latched piece; a runs along direcao, b across it.
  always_comb begin
    len_d = 3'd0;
    case (tipo_q)
      3'd0:    len_d = 3'd1;
      3'd1:    len_d = 3'd2;
      3'd2:    len_d = 3'd3;
      3'd3:    len_d = 3'd4;
      3'd4:    len_d = 3'd5;
      default: len_d = 3'd0;
    endcase
    a_d         = {2'b00, k_q};
    b_d         = (tipo_q == 3'd2 && k_q == 3'd1) ? 5'd1 : 5'd0;
    cx_d        = {1'b0, x_q} + (dir_q ? b_d : a_d);
    cy_d        = {1'b0, y_q} + (dir_q ? a_d : b_d);
    in_range_d  = (cx_d <= 5'd9) && (cy_d <= 5'd9);
    idx_d       = 7'(cy_d) * 7'd10 + 7'(cx_d);
    // Undefined piece types have no cells and are rejected outright.
    cell_conf_d = (len_d == 3'd0) || !in_range_d ||
                  (in_range_d ? board_q[jog_q][idx_d] : 1'b0);
    last_d        = (k_q == len_d - 3'd1);
    valida_edge_d = bus.valida && !valida_prev_q;
    rd_idx_d      = 7'(bus.rd_y) * 7'd10 + 7'(bus.rd_x);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      board_q[0]    <= '0;
      board_q[1]    <= '0;
      celulas_q[0]  <= '0;
      celulas_q[1]  <= '0;
      jog_q         <= 1'b0;
      tipo_q        <= 3'd0;
      x_q           <= 4'd0;
      y_q           <= 4'd0;
      dir_q         <= 1'b0;
      k_q           <= 3'd0;
      apto_q        <= 1'b0;
      conflito_q    <= 1'b0;
      pronto_q      <= 1'b0;
      gravado_q     <= 1'b0;
      valida_prev_q <= 1'b0;
    end else begin
      valida_prev_q <= bus.valida;
      pronto_q      <= 1'b0;
      gravado_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.limpa) begin
            jog_q   <= bus.jogador;
            state_q <= CLEAR;
          end else if (bus.grava && apto_q) begin
            k_q     <= 3'd0;
            state_q <= COMMIT;
          end else if (valida_edge_d) begin
            jog_q   <= bus.jogador;
            tipo_q  <= bus.tipo;
            x_q     <= bus.X1;
            y_q     <= bus.Y1;
            dir_q   <= bus.direcao;
            k_q     <= 3'd0;
            apto_q  <= 1'b0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (cell_conf_d) begin
            conflito_q <= 1'b1;
            pronto_q   <= 1'b1;
            state_q    <= RESULT;
          end else if (last_d) begin
            conflito_q <= 1'b0;
            apto_q     <= 1'b1;
            pronto_q   <= 1'b1;
            state_q    <= RESULT;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        RESULT: state_q <= IDLE;
        COMMIT: begin
          board_q[jog_q][idx_d] <= 1'b1;
          if (last_d) begin
            gravado_q        <= 1'b1;
            apto_q           <= 1'b0;
            celulas_q[jog_q] <= celulas_q[jog_q] + {4'b0000, len_d};
            state_q          <= IDLE;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        CLEAR: begin
          board_q[jog_q]   <= '0;
          celulas_q[jog_q] <= '0;
          apto_q           <= 1'b0;
          state_q          <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.conflito = conflito_q;
  assign bus.pronto   = pronto_q;
  assign bus.gravado  = gravado_q;
  assign bus.ocupado  = (state_q != IDLE);
  assign bus.celulas0 = celulas_q[0];
  assign bus.celulas1 = celulas_q[1];
  assign bus.rd_cel   = (bus.rd_x <= 4'd9 && bus.rd_y <= 4'd9) ?
                        board_q[bus.rd_jogador][rd_idx_d] : 1'b0;

endmodule

// File: tb/tb_validador_pecas.sv
// Directed bench for validador_pecas: latencies, conflicts, commits, clears
// and asynchronous reset in the middle of a commit.
module tb_validador_pecas;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   lat;
  logic v;
  int   ones;

  validador_pecas_if bus ();

  validador_pecas dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns pronto latency counted from the sampling edge (n+L+1 style), -1 on timeout.
  task automatic do_valida(input logic j, input int t, input int x, input int y,
                           input logic d, output int l);
    int k;
    @(negedge clk);
    bus.jogador = j;
    bus.tipo    = 3'(t);
    bus.X1      = 4'(x);
    bus.Y1      = 4'(y);
    bus.direcao = d;
    bus.valida  = 1'b1;
    @(posedge clk);
    k = 0;
    l = -1;
    while (k < 20) begin
      @(negedge clk);
      bus.valida = 1'b0;
      if (bus.pronto) begin
        l = k + 1;
        break;
      end
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    $display("valida j=%0d tipo=%0d (%0d,%0d) dir=%0d -> lat=%0d conflito=%0d",
             j, t, x, y, d, l, bus.conflito);
  endtask

  // Returns number of edges from grava sample to gravado, -1 if none.
  task automatic do_grava(output int l);
    int k;
    @(negedge clk);
    bus.grava = 1'b1;
    @(posedge clk);
    k = 0;
    l = -1;
    while (k < 12) begin
      @(negedge clk);
      bus.grava = 1'b0;
      if (bus.gravado) begin
        l = k;
        break;
      end
      @(posedge clk);
      k++;
    end
    $display("grava -> gravado after %0d cycles, celulas0=%0d celulas1=%0d",
             l, bus.celulas0, bus.celulas1);
  endtask

  task automatic do_limpa(input logic j);
    @(negedge clk);
    bus.jogador = j;
    bus.limpa   = 1'b1;
    @(negedge clk);
    bus.limpa = 1'b0;
    @(negedge clk);
    $display("limpa j=%0d -> celulas0=%0d celulas1=%0d", j, bus.celulas0, bus.celulas1);
  endtask

  task automatic rd_cell(input logic j, input int x, input int y, output logic c);
    bus.rd_jogador = j;
    bus.rd_x       = 4'(x);
    bus.rd_y       = 4'(y);
    #1;
    c = bus.rd_cel;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.valida = 1'b0;
    bus.grava = 1'b0;
    bus.limpa = 1'b0;
    bus.jogador = 1'b0;
    bus.tipo = 3'd0;
    bus.X1 = 4'd0;
    bus.Y1 = 4'd0;
    bus.direcao = 1'b0;
    bus.rd_jogador = 1'b0;
    bus.rd_x = 4'd0;
    bus.rd_y = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check_eq("rst_ocupado", int'(bus.ocupado), 0);
    check_eq("rst_pronto", int'(bus.pronto), 0);
    check_eq("rst_conflito", int'(bus.conflito), 0);
    check_eq("rst_gravado", int'(bus.gravado), 0);
    check_eq("rst_celulas0", int'(bus.celulas0), 0);
    check_eq("rst_celulas1", int'(bus.celulas1), 0);

    // Five-cell carrier on an empty board.
    do_valida(1'b0, 4, 0, 0, 1'b0, lat);
    check_eq("pa_lat", lat, 6);
    check_eq("pa_conflito", int'(bus.conflito), 0);
    do_grava(lat);
    check_eq("pa_grava_lat", lat, 5);
    check_eq("pa_celulas0", int'(bus.celulas0), 5);
    rd_cell(1'b0, 4, 0, v);  check_eq("rd_0_4_0", int'(v), 1);
    rd_cell(1'b0, 5, 0, v);  check_eq("rd_0_5_0", int'(v), 0);
    rd_cell(1'b1, 0, 0, v);  check_eq("rd_1_0_0", int'(v), 0);

    do_valida(1'b0, 1, 4, 0, 1'b1, lat);
    check_eq("cr_lat", lat, 2);
    check_eq("cr_conflito", int'(bus.conflito), 1);

    do_valida(1'b0, 3, 7, 2, 1'b0, lat);
    check_eq("enc_lat", lat, 5);
    check_eq("enc_conflito", int'(bus.conflito), 1);

    do_grava(lat);
    check_eq("grava_no_apto", lat, -1);
    check_eq("grava_no_apto_cel0", int'(bus.celulas0), 5);
    rd_cell(1'b0, 7, 2, v);  check_eq("rd_0_7_2", int'(v), 0);

    // Seaplane on board 1, horizontal: (2,5),(3,6),(4,5).
    do_valida(1'b1, 2, 2, 5, 1'b0, lat);
    check_eq("hid_lat", lat, 4);
    check_eq("hid_conflito", int'(bus.conflito), 0);
    do_grava(lat);
    check_eq("hid_grava_lat", lat, 3);
    check_eq("hid_celulas1", int'(bus.celulas1), 3);
    rd_cell(1'b1, 3, 6, v);  check_eq("rd_1_3_6", int'(v), 1);
    rd_cell(1'b1, 3, 5, v);  check_eq("rd_1_3_5", int'(v), 0);
    rd_cell(1'b1, 4, 5, v);  check_eq("rd_1_4_5", int'(v), 1);

    // Vertical seaplane on board 0: (0,1),(1,2),(0,3).
    do_valida(1'b0, 2, 0, 1, 1'b1, lat);
    check_eq("hidv_lat", lat, 4);
    check_eq("hidv_conflito", int'(bus.conflito), 0);
    do_grava(lat);
    check_eq("hidv_celulas0", int'(bus.celulas0), 8);
    rd_cell(1'b0, 1, 2, v);  check_eq("rd_0_1_2", int'(v), 1);
    rd_cell(1'b0, 0, 1, v);  check_eq("rd_0_0_1", int'(v), 1);
    rd_cell(1'b0, 10, 0, v); check_eq("rd_0_10_0", int'(v), 0);

    do_valida(1'b0, 5, 0, 8, 1'b0, lat);
    check_eq("tipo5_lat", lat, 2);
    check_eq("tipo5_conflito", int'(bus.conflito), 1);
    do_valida(1'b0, 0, 15, 0, 1'b0, lat);
    check_eq("x15_conflito", int'(bus.conflito), 1);
    do_valida(1'b0, 0, 9, 9, 1'b0, lat);
    check_eq("sub99_lat", lat, 2);
    check_eq("sub99_conflito", int'(bus.conflito), 0);

    do_limpa(1'b1);
    check_eq("limpa_celulas1", int'(bus.celulas1), 0);
    check_eq("limpa_celulas0", int'(bus.celulas0), 8);
    rd_cell(1'b1, 3, 6, v);  check_eq("rd_limpa_1_3_6", int'(v), 0);

    // Reset in the middle of a commit on row 9.
    do_valida(1'b0, 4, 0, 9, 1'b0, lat);
    check_eq("pa9_lat", lat, 6);
    @(negedge clk);
    bus.grava = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.grava = 1'b0;
    check_eq("commit_ocupado", int'(bus.ocupado), 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_ocupado", int'(bus.ocupado), 0);
    check_eq("mid_rst_celulas0", int'(bus.celulas0), 0);
    check_eq("mid_rst_gravado", int'(bus.gravado), 0);
    ones = 0;
    for (int j = 0; j < 2; j++)
      for (int y = 0; y < 10; y++)
        for (int x = 0; x < 10; x++) begin
          rd_cell(1'(j), x, y, v);
          ones += int'(v);
        end
    check_eq("mid_rst_board_ones", ones, 0);
    $display("reset mid-commit -> occupied cells=%0d celulas0=%0d", ones, bus.celulas0);
    @(negedge clk);
    reset = 1'b1;
    do_valida(1'b0, 0, 0, 0, 1'b0, lat);
    check_eq("post_rst_conflito", int'(bus.conflito), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/validador_pecas.md
VALIDADOR_PECAS -- requirements
Module: validador_pecas

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have reset, input, 1, asynchronous, active-low; clears all state and both boards.
REQ-003 SHALL have valida, input, 1, check request; only its rising edge, sampled on clk, is acted on.
REQ-004 SHALL have grava, input, 1, single-cycle pulse that commits the last validated piece.
REQ-005 SHALL have limpa, input, 1, single-cycle pulse that clears the board of the selected jogador.
REQ-006 SHALL have jogador, input, 1, board select: 0 = player 0, 1 = player 1.
REQ-007 SHALL have tipo, input, 3, piece type: 0 submarino, 1 cruzador, 2 hidroaviao, 3 encouracado, 4 porta-avioes.
REQ-008 SHALL have X1 and Y1, input, 4 each, anchor column and row; the valid range is 0..9.
REQ-009 SHALL have direcao, input, 1, piece direction: 0 horizontal (+X), 1 vertical (+Y).
REQ-010 SHALL have conflito, output, 1, result of the last check: 1 = rejected.
REQ-011 SHALL have pronto, output, 1, one-cycle strobe marking that conflito is valid.
REQ-012 SHALL have ocupado, output, 1, high in every state except IDLE.
REQ-013 SHALL have gravado, output, 1, one-cycle strobe when a commit completes.
REQ-014 SHALL have rd_jogador (1), rd_x (4) and rd_y (4) inputs, plus rd_cel (1) output: combinational read port; rd_cel = 0 for any coordinate above 9.
REQ-015 SHALL have celulas0 and celulas1, outputs, 7 each, occupied-cell count per board.

Function
REQ-016 SHALL store two 10x10 occupancy bit boards internally.
REQ-017 SHALL define piece cells relative to (X1,Y1), with a and b meaning the offsets along and across direcao:
- tipo 0: 1 cell.
- tipo 1: 2 cells in line.
- tipo 3: 4 cells in line.
- tipo 4: 5 cells in line.
- tipo 2: 3 cells at (a,b) = (0,0), (1,1), (2,0).
- tipo 5-7: always conflito = 1.
REQ-018 SHALL implement the FSM states IDLE, CHECK, RESULT, COMMIT and CLEAR.
REQ-019 SHALL leave IDLE on a valida rising edge by latching jogador, tipo, X1, Y1 and direcao, clearing index k, and entering CHECK.
REQ-020 SHALL, in CHECK, evaluate cell k each cycle; the cell conflicts when its coordinate exceeds 9 or its board bit is 1.
REQ-021 SHALL go from CHECK to RESULT on the first conflicting cell with conflito = 1, or after the last cell with conflito = 0.
REQ-022 SHALL, in RESULT, assert pronto for exactly one cycle, then return to IDLE.
REQ-023 SHALL hold conflito until the next RESULT.
REQ-024 SHALL give a no-conflict latency from the valida edge sample in cycle n to pronto in cycle n+L+1, where L is the cell count.
REQ-025 SHALL set flag apto in RESULT when conflito = 0.
REQ-026 SHALL act on grava only in IDLE with apto = 1: enter COMMIT and write one latched cell per cycle for L cycles.
REQ-027 SHALL, after the last COMMIT write, pulse gravado, clear apto, add L to the matching celulas counter, and return to IDLE.
REQ-028 SHALL ignore grava when apto = 0 or when not in IDLE; no write occurs and no strobe is produced.
REQ-029 SHALL clear apto on any new valida edge.
REQ-030 SHALL ignore valida edges while ocupado = 1; they are not queued.
REQ-031 SHALL, on limpa in IDLE, use CLEAR for one cycle to zero the selected board, its counter and apto, then return to IDLE.
REQ-032 SHALL give priority limpa > grava > valida when these occur together in IDLE.
REQ-033 SHALL perform coordinate arithmetic at 5 bits so that X1 + 4 never wraps.

Reset
REQ-034 SHALL, while reset = 0, force the state to IDLE and clear both boards, celulas0, celulas1, conflito, pronto, gravado, apto and k.
REQ-035 SHALL, on reset mid-CHECK or mid-COMMIT, abort immediately; a partially written piece is cleared along with the boards.

Verification
REQ-036 SHALL pass: empty board, valida with tipo 4, (0,0), direcao 0 -> pronto at cycle n+6, conflito = 0.
REQ-037 SHALL pass: then grava -> gravado after 5 cycles, celulas0 = 5, rd_cel(0,4,0) = 1.
REQ-038 SHALL pass: valida with tipo 1, (4,0), direcao 1 on that board -> conflito = 1, pronto at cycle n+2.
REQ-039 SHALL pass: tipo 3, (7,2), direcao 0 -> conflito = 1 (cell X = 10).
REQ-040 SHALL pass: grava without a preceding clean check -> no gravado, board unchanged.
REQ-041 SHALL pass: reset pulse mid-COMMIT -> all rd_cel = 0, celulas0 = 0, state IDLE.
